cdb_arb: RTL and testbench

- Arbitrates the single common data bus (CDB) among N functional-unit result ports: ALU, MUL/DIV, LSU and branch.
- Grants one requester per cycle using round-robin priority, then registers the winner's tag/data onto the CDB.
- The register-file unit and the reservation stations snoop this registered CDB to wake up operands and clear busy bits.

---
 rtl/cdb_arb_pkg.sv | 23 ++
 rtl/cdb_arb_if.sv | 35 +++
 rtl/cdb_arb_rr_arb.sv | 28 ++
 rtl/cdb_arb.sv | 91 +++++++++
 tb/tb_cdb_arb.sv | 129 ++++++++++++
 5 files changed

// File: rtl/cdb_arb_pkg.sv
// Shared core types for the CDB arbiter: bus widths, the CDB beat record and FU port ordering.
package core_pkg;
  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  wr;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] wdata;
  } cdb_beat_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MDU = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_idx_e;

  // Round-robin pointer advance: the slot after the winner, wrapping at n.
  function automatic int rr_next(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/cdb_arb_if.sv
// FU result request bus plus the registered CDB broadcast. Perf counters exist only with CDB_ARB_PERF_EN.
interface cdb_arb_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic                      flush;
  logic [N_REQ-1:0]          req_vld;
  logic [N_REQ*TAG_W-1:0]    req_tag;
  logic [N_REQ*DATA_W-1:0]   req_wdata;
  logic [N_REQ-1:0]          req_rdy;
  logic                      cdb_wr;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_wdata;
`ifdef CDB_ARB_PERF_EN
  logic [N_REQ*32-1:0]       perf_grant_cnt;
  logic [31:0]               perf_conflict_cnt;
`endif

  modport master (
    output flush, req_vld, req_tag, req_wdata,
`ifdef CDB_ARB_PERF_EN
    input  perf_grant_cnt, perf_conflict_cnt,
`endif
    input  req_rdy, cdb_wr, cdb_tag, cdb_wdata
  );

  modport slave (
    input  flush, req_vld, req_tag, req_wdata,
`ifdef CDB_ARB_PERF_EN
    output perf_grant_cnt, perf_conflict_cnt,
`endif
    output req_rdy, cdb_wr, cdb_tag, cdb_wdata
  );
endinterface

// File: rtl/cdb_arb_rr_arb.sv
// N-way round-robin picker: first set req bit at or after ptr (wrapping) wins, one-hot plus index.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arb.sv
// Common data bus arbiter: round-robin grant among FU result ports, winner registered onto the CDB.
// Optional CDB_ARB_PERF_EN adds saturating per-unit grant and conflict counters.
module cdb_arb
  import core_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic     clk,
  input  logic     rst_n,
  cdb_arb_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [N_REQ-1:0] req_m, gnt;
  logic             any_gnt;
  logic [TAG_W-1:0] sel_tag;
  logic [DATA_W-1:0] sel_wdata;
  logic             cdb_wr_q;
  logic [TAG_W-1:0] cdb_tag_q;
  logic [DATA_W-1:0] cdb_wdata_q;

  // Flush and reset both suppress the grant, so req_rdy stays purely combinational from inputs.
  assign req_m = bus.req_vld & {N_REQ{rst_n & ~bus.flush}};

  rr_arb #(.N(N_REQ), .IW(IW)) u_rr (
    .req_i     (req_m),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_gnt)
  );

  assign bus.req_rdy = gnt;

  always_comb begin
    sel_tag   = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_tag   = bus.req_tag[i*TAG_W +: TAG_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_ptr_d = any_gnt ? IW'(rr_next(int'(gnt_idx), N_REQ)) : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_wr_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_wr_q    <= any_gnt;
      cdb_tag_q   <= sel_tag;
      cdb_wdata_q <= sel_wdata;
    end
  end

  assign bus.cdb_wr    = cdb_wr_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_wdata = cdb_wdata_q;

`ifdef CDB_ARB_PERF_EN
  logic [N_REQ-1:0][31:0] perf_gnt_q;
  logic [31:0]            perf_cfl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt_q <= '0;
      perf_cfl_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (gnt[i] && perf_gnt_q[i] != '1) perf_gnt_q[i] <= perf_gnt_q[i] + 32'd1;
      if (!bus.flush && $countones(bus.req_vld) > 1 && perf_cfl_q != '1)
        perf_cfl_q <= perf_cfl_q + 32'd1;
    end
  end

  assign bus.perf_grant_cnt    = perf_gnt_q;
  assign bus.perf_conflict_cnt = perf_cfl_q;
`endif

  // Tag 0 means "no producer"; a granted result carrying it would corrupt wakeup.
  a_no_tag0: assert property (@(posedge clk) disable iff (!rst_n) any_gnt |-> sel_tag != '0);
endmodule

// File: tb/tb_cdb_arb.sv
// Directed table-driven bench for cdb_arb plus reset-mid-burst and perf-counter sequences.
module tb_cdb_arb;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cdb_arb_if #(.N_REQ(4), .TAG_W(4), .DATA_W(32)) bus ();

  cdb_arb #(.N_REQ(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       flush;
    logic [3:0] vld;
    logic [3:0] rdy;   // expected comb grant this row
    logic       wr;    // expected CDB beat from previous row's grant
    logic [3:0] tag;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cdb_beat_t exp_beat(input logic wr, input logic [3:0] tag);
    cdb_beat_t b;
    b.wr    = wr;
    b.tag   = wr ? tag : 4'd0;
    b.wdata = wr ? (32'hC0DE_0000 | (32'(tag) - 32'd1)) : 32'd0;
    return b;
  endfunction

  task automatic chk_cdb(input string name, input cdb_beat_t e);
    chk({name, " cdb_wr"},    32'(bus.cdb_wr),  32'(e.wr));
    chk({name, " cdb_tag"},   32'(bus.cdb_tag), 32'(e.tag));
    chk({name, " cdb_wdata"}, bus.cdb_wdata,    e.wdata);
  endtask

  initial begin
    //            flush  vld      rdy      wr  tag
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 4'd1};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 4'd2};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 4'd3};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 4'd4};
    vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'd1};
    vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'd3};
    vecs[8]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'd3};
    vecs[9]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 4'd3};
    vecs[10] = '{1'b0, 4'b1001, 4'b0001, 1'b1, 4'd4};
    vecs[11] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'd1};
    vecs[12] = '{1'b1, 4'b0011, 4'b0000, 1'b1, 4'd2};
    vecs[13] = '{1'b0, 4'b0011, 4'b0001, 1'b0, 4'd0};
    vecs[14] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 4'd1};
    vecs[15] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'd2};
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.req_vld   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_tag[i*4 +: 4]     = 4'(i + 1);
      bus.req_wdata[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_rdy", 32'(bus.req_rdy), 32'd0);
    chk_cdb("reset", exp_beat(1'b0, 4'd0));
    rst_n = 1'b1;

    for (int r = 0; r < 17; r++) begin
      bus.flush   = vecs[r].flush;
      bus.req_vld = vecs[r].vld;
      #1;
      chk($sformatf("row%0d req_rdy", r), 32'(bus.req_rdy), 32'(vecs[r].rdy));
      chk_cdb($sformatf("row%0d", r), exp_beat(vecs[r].wr, vecs[r].tag));
      @(posedge clk);
      #1;
    end

    // Reset mid-burst: pointer sits at 2, so index 2 is on the CDB when reset hits.
    bus.req_vld = 4'b1111;
    @(posedge clk);
    #1;
    chk_cdb("burst", exp_beat(1'b1, 4'd3));
    rst_n = 1'b0;
    #1;
    chk_cdb("async reset", exp_beat(1'b0, 4'd0));
    chk("async reset req_rdy", 32'(bus.req_rdy), 32'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.req_vld = 4'b0110;
    #1;
    chk("post-reset lowest", 32'(bus.req_rdy), 32'b0010);
    bus.req_vld = 4'b0011;
    #1;
    chk("post-reset ptr0", 32'(bus.req_rdy), 32'b0001);

    repeat (10) @(posedge clk);
    #1;
    bus.req_vld = 4'b0000;
    chk_cdb("alt tail", exp_beat(1'b1, 4'd2));
`ifdef CDB_ARB_PERF_EN
    chk("perf_grant_cnt[0]", bus.perf_grant_cnt[0*32 +: 32], 32'd5);
    chk("perf_grant_cnt[1]", bus.perf_grant_cnt[1*32 +: 32], 32'd5);
    chk("perf_grant_cnt[2]", bus.perf_grant_cnt[2*32 +: 32], 32'd0);
    chk("perf_conflict_cnt", bus.perf_conflict_cnt, 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
